fifo_wr_arbiter: RTL

//   Round-robin write arbiter that shares one synchronous FIFO write port among
//   NUM_REQ producers. It grants one producer at a time, lets it burst up to
//   MAX_BURST words, and drives the FIFO's wr_en/data_in from the granted lane.
//   It sits directly in front of the FIFO and honours the FIFO's combinational

---
 rtl/fifo_wr_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Each grant may burst up to MAX_BURST words; the FIFO full flag is honoured every cycle.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int                ID_W     = $clog2(NUM_REQ);
  localparam int                CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [ID_W:0]     NREQ     = (ID_W + 1)'(NUM_REQ);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic {ARB, LOCK} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   rr_last_q, rr_last_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic              busy_q, busy_d;

  logic              any_req;
  logic [ID_W-1:0]   pick;
  logic              owner_valid;
  logic              owner_last;

  // Rotating priority scan starting just after the last owner; the sum is one
  // bit wider so a single conditional subtract handles non-power-of-2 NUM_REQ.
  always_comb begin
    logic [ID_W:0] idx;
    logic          found;
    idx     = '0;
    found   = 1'b0;
    pick    = '0;
    any_req = |req_valid;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, rr_last_q} + (ID_W + 1)'(k);
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    owner_valid  = 1'b0;
    owner_last   = 1'b0;
    fifo_data_in = '0;
    req_ready    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        owner_valid  = req_valid[i];
        owner_last   = req_last[i];
        fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready[i] = (state_q == LOCK) & ~fifo_full;
      end
    end
    fifo_wr_en = (state_q == LOCK) & owner_valid & ~fifo_full;
  end

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_last_d   = rr_last_q;
    burst_cnt_d = burst_cnt_q;
    busy_d      = busy_q;
    case (state_q)
      ARB: begin
        if (any_req) begin
          grant_id_d  = pick;
          busy_d      = 1'b1;
          burst_cnt_d = '0;
          state_d     = LOCK;
        end
      end
      LOCK: begin
        // A stalled owner (valid but FIFO full) keeps the grant without consuming burst budget.
        if (fifo_wr_en && !(owner_last || burst_cnt_q == CNT_LAST)) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end else if (fifo_wr_en || !owner_valid) begin
          rr_last_d   = grant_id_q;
          busy_d      = 1'b0;
          burst_cnt_d = '0;
          state_d     = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      grant_id_q  <= '0;
      rr_last_q   <= ID_LAST;
      burst_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_last_q   <= rr_last_d;
      burst_cnt_q <= burst_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule
